// File: rtl/spi_burst_reg_bridge.sv
// SPI mode-0 slave bridging serial frames to a TinyQV peripheral register port.
// Frame: command byte (bit7 = write, low ADDR_W bits = start address), then
// one or more data bytes. Burst accesses auto-increment the address modulo
// 2^ADDR_W. Reads pulse reg_rd_stb when a byte is fetched from reg_data_i so
// read-side-effect registers see exactly one access per byte shifted out.
module spi_burst_reg_bridge #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              spi_cs_n,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] reg_addr,
    input  logic [DATA_W-1:0] reg_data_i,
    output logic [DATA_W-1:0] reg_data_o,
    output logic              reg_data_o_dv,
    output logic              reg_rd_stb
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_WDATA,
        S_RDATA
    } state_t;

    state_t              r_state;
    logic                r_sck_prev;
    logic                r_armed;      // cs_n seen high since reset
    logic [2:0]          r_bit_cnt;
    logic [DATA_W-2:0]   r_shift_in;   // bits already received of the current byte
    logic [DATA_W-2:0]   r_shift_out;  // bits still to be sent after the current one
    logic                r_load_pend;  // next SCK fall fetches a fresh read byte
    logic                r_miso;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data_o;
    logic                r_wr_stb;
    logic                r_rd_stb;

    logic                w_rise;
    logic                w_fall;
    logic                w_last_bit;
    logic [DATA_W-1:0]   w_byte;

    // SCK edges in the clk domain; disabled bridge sees no edges at all
    assign w_rise     = ena & spi_clk & ~r_sck_prev;
    assign w_fall     = ena & ~spi_clk & r_sck_prev;
    assign w_last_bit = (r_bit_cnt == 3'd7);
    assign w_byte     = {r_shift_in, spi_mosi};

    // Frame FSM, shift registers, address counter and strobes
    // NOTE: every register here is assigned with <= so all branches see the
    // pre-edge values, matching the flops the synthesizer builds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sck_prev  <= 1'b0;
            r_armed     <= 1'b0;
            r_bit_cnt   <= 3'd0;
            r_shift_in  <= '0;
            r_shift_out <= '0;
            r_load_pend <= 1'b0;
            r_miso      <= 1'b0;
            r_addr      <= '0;
            r_data_o    <= '0;
            r_wr_stb    <= 1'b0;
            r_rd_stb    <= 1'b0;
        end else begin
            r_sck_prev <= spi_clk;
            // NOTE: strobes default low each cycle so a set below lasts one clk.
            r_wr_stb   <= 1'b0;
            r_rd_stb   <= 1'b0;

            // Address advances the clk after the write strobe, so the strobe
            // cycle still presents the written address.
            if (r_wr_stb) begin
                r_addr <= r_addr + ADDR_W'(1);
            end

            if (!ena) begin
                r_miso <= 1'b0;
            end

            if (spi_cs_n) begin
                // Deselect wins over any SCK edge; a partial byte is dropped.
                r_state     <= S_IDLE;
                r_armed     <= 1'b1;
                r_bit_cnt   <= 3'd0;
                r_load_pend <= 1'b0;
                r_miso      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // Unarmed means reset hit mid-frame: wait for cs_n high.
                        if (r_armed) begin
                            r_state   <= S_CMD;
                            r_bit_cnt <= 3'd0;
                        end
                    end

                    S_CMD: begin
                        if (w_rise) begin
                            r_shift_in <= w_byte[DATA_W-2:0];
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            if (w_last_bit) begin
                                r_addr <= w_byte[ADDR_W-1:0];
                                if (w_byte[DATA_W-1]) begin
                                    r_state <= S_WDATA;
                                end else begin
                                    r_state     <= S_RDATA;
                                    r_load_pend <= 1'b1;
                                end
                            end
                        end
                    end

                    S_WDATA: begin
                        if (w_rise) begin
                            r_shift_in <= w_byte[DATA_W-2:0];
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            if (w_last_bit) begin
                                r_data_o <= w_byte;
                                r_wr_stb <= 1'b1;
                            end
                        end
                    end

                    S_RDATA: begin
                        if (w_fall) begin
                            if (r_load_pend) begin
                                r_shift_out <= reg_data_i[DATA_W-2:0];
                                r_miso      <= reg_data_i[DATA_W-1];
                                r_rd_stb    <= 1'b1;
                                r_load_pend <= 1'b0;
                            end else begin
                                r_miso      <= r_shift_out[DATA_W-2];
                                r_shift_out <= {r_shift_out[DATA_W-3:0], 1'b0};
                            end
                        end else if (w_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_last_bit) begin
                                r_addr      <= r_addr + ADDR_W'(1);
                                r_load_pend <= 1'b1;
                            end
                        end
                    end

                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign spi_miso      = r_miso;
    assign reg_addr      = r_addr;
    assign reg_data_o    = r_data_o;
    assign reg_data_o_dv = r_wr_stb;
    assign reg_rd_stb    = r_rd_stb;

endmodule

// File: tb/tb_spi_burst_reg_bridge.sv
// Directed bench for spi_burst_reg_bridge. Stimulus pushes expected write
// strobes, read strobes and MISO bytes into queues; a monitor pops and
// compares whenever the bridge presents a strobe or a full MISO byte.
module tb_spi_burst_reg_bridge;

    localparam int HALF = 4;  // SCK half period in clk cycles

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       spi_cs_n;
    logic       spi_clk;
    logic       spi_mosi;
    logic       spi_miso;
    logic [3:0] reg_addr;
    logic [7:0] reg_data_i;
    logic [7:0] reg_data_o;
    logic       reg_data_o_dv;
    logic       reg_rd_stb;

    spi_burst_reg_bridge #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .ena           (ena),
        .spi_cs_n      (spi_cs_n),
        .spi_clk       (spi_clk),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .reg_addr      (reg_addr),
        .reg_data_i    (reg_data_i),
        .reg_data_o    (reg_data_o),
        .reg_data_o_dv (reg_data_o_dv),
        .reg_rd_stb    (reg_rd_stb)
    );

    always #5 clk = ~clk;

    // Peripheral model: each register reads back its own address, except 2.
    logic [7:0] mem [16];
    assign reg_data_i = mem[reg_addr];

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        q_wr[$];
    logic [3:0] q_rd[$];
    logic [7:0] q_miso[$];

    int   n_vec = 0;
    int   n_err = 0;
    logic rd_active = 1'b0;
    logic dis_miso_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got 0x%0h, expected nothing", name, act);
    endtask

    // Monitor: sample away from the active edge
    initial begin : monitor
        logic       sck_q;
        logic       prev_stb;
        logic [7:0] rx;
        int         rx_cnt;
        wr_t        e;
        sck_q    = 1'b0;
        prev_stb = 1'b0;
        rx       = 8'h00;
        rx_cnt   = 0;
        forever begin
            @(negedge clk);
            if (reg_data_o_dv) begin
                if (q_wr.size() == 0) begin
                    unexpected("wr_stb", {28'h0, reg_addr});
                end else begin
                    e = q_wr.pop_front();
                    check("wr_addr", reg_addr, e.addr);
                    check("wr_data", reg_data_o, e.data);
                end
            end
            if (reg_rd_stb) begin
                if (q_rd.size() == 0) begin
                    unexpected("rd_stb", {28'h0, reg_addr});
                end else begin
                    check("rd_addr", reg_addr, q_rd.pop_front());
                end
            end
            if (reg_data_o_dv && reg_rd_stb) begin
                unexpected("dv_and_rd_same_cycle", 32'h1);
            end
            if (prev_stb && (reg_data_o_dv || reg_rd_stb)) begin
                unexpected("back_to_back_strobe", 32'h1);
            end
            prev_stb = reg_data_o_dv | reg_rd_stb;
            if (!ena && spi_miso) begin
                dis_miso_seen = 1'b1;
            end
            if (!rd_active) begin
                rx_cnt = 0;
            end else if (spi_clk && !sck_q) begin
                rx = {rx[6:0], spi_miso};
                rx_cnt++;
                if (rx_cnt == 8) begin
                    rx_cnt = 0;
                    if (q_miso.size() == 0) begin
                        unexpected("miso_byte", {24'h0, rx});
                    end else begin
                        check("miso_byte", rx, q_miso.pop_front());
                    end
                end
            end
            sck_q = spi_clk;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Send the top n bits of v, MSB first; SCK is left high after the last bit.
    task automatic spi_bits(input logic [7:0] v, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            spi_clk  = 1'b0;
            spi_mosi = v[i];
            tick(HALF);
            spi_clk  = 1'b1;
            tick(HALF);
        end
    endtask

    task automatic cs_start();
        spi_cs_n = 1'b0;
        tick(HALF);
    endtask

    // Frames end with CS released while SCK is still high, so no trailing
    // SCK fall prefetches another read byte.
    task automatic cs_end();
        tick(HALF);
        spi_cs_n  = 1'b1;
        rd_active = 1'b0;
        tick(2);
        spi_clk = 1'b0;
        tick(2 * HALF);
    endtask

    task automatic push_wr(input logic [3:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        q_wr.push_back(w);
    endtask

    initial begin : stimulus
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        mem[2] = 8'h3C;

        rst      = 1'b1;
        ena      = 1'b1;
        spi_cs_n = 1'b1;
        spi_clk  = 1'b0;
        spi_mosi = 1'b0;
        tick(4);
        check("rst_addr", reg_addr, 4'h0);
        check("rst_data_o", reg_data_o, 8'h00);
        check("rst_miso", spi_miso, 1'b0);
        check("rst_dv", reg_data_o_dv, 1'b0);
        check("rst_rd_stb", reg_rd_stb, 1'b0);
        rst = 1'b0;
        tick(4);

        // Single write
        cs_start();
        spi_bits(8'h85, 8);
        push_wr(4'd5, 8'hA5);
        spi_bits(8'hA5, 8);
        cs_end();
        check("wr1_data_hold", reg_data_o, 8'hA5);

        // Single read from register 2
        cs_start();
        spi_bits(8'h02, 8);
        q_rd.push_back(4'd2);
        q_miso.push_back(8'h3C);
        rd_active = 1'b1;
        spi_bits(8'h00, 8);
        cs_end();

        // Burst write wrapping 14, 15, 0
        cs_start();
        spi_bits(8'h8E, 8);
        push_wr(4'd14, 8'h11);
        spi_bits(8'h11, 8);
        push_wr(4'd15, 8'h22);
        spi_bits(8'h22, 8);
        push_wr(4'd0, 8'h33);
        spi_bits(8'h33, 8);
        cs_end();
        check("burst_wr_end_addr", reg_addr, 4'd1);

        // Burst read from 7: two bytes
        cs_start();
        spi_bits(8'h07, 8);
        q_rd.push_back(4'd7);
        q_rd.push_back(4'd8);
        q_miso.push_back(8'h07);
        q_miso.push_back(8'h08);
        rd_active = 1'b1;
        spi_bits(8'hFF, 8);
        spi_bits(8'hFF, 8);
        cs_end();
        check("burst_rd_end_addr", reg_addr, 4'd9);

        // Abort after 5 data bits, then a normal write to 1
        cs_start();
        spi_bits(8'h83, 8);
        spi_bits(8'hFF, 5);
        cs_end();
        check("abort_addr_hold", reg_addr, 4'd3);
        check("abort_data_hold", reg_data_o, 8'h33);
        check("abort_miso", spi_miso, 1'b0);
        cs_start();
        spi_bits(8'h81, 8);
        push_wr(4'd1, 8'h5A);
        spi_bits(8'h5A, 8);
        cs_end();
        check("post_abort_addr", reg_addr, 4'd2);

        // Disabled bridge: full write frame must be ignored
        ena = 1'b0;
        cs_start();
        spi_bits(8'h84, 8);
        spi_bits(8'h77, 8);
        cs_end();
        ena = 1'b1;
        check("ena0_addr", reg_addr, 4'd2);
        check("ena0_data", reg_data_o, 8'h5A);

        // Reset mid-write; rest of the frame must be ignored
        cs_start();
        spi_bits(8'h85, 8);
        spi_bits(8'hF0, 4);
        rst = 1'b1;
        tick(2);
        check("midrst_addr", reg_addr, 4'h0);
        check("midrst_data_o", reg_data_o, 8'h00);
        check("midrst_miso", spi_miso, 1'b0);
        check("midrst_dv", reg_data_o_dv, 1'b0);
        check("midrst_rd_stb", reg_rd_stb, 1'b0);
        rst = 1'b0;
        spi_bits(8'hA0, 4);
        spi_bits(8'hFF, 8);
        cs_end();
        check("midrst_tail_addr", reg_addr, 4'h0);
        check("midrst_tail_data", reg_data_o, 8'h00);

        // Recovery write
        cs_start();
        spi_bits(8'h89, 8);
        push_wr(4'd9, 8'hC3);
        spi_bits(8'hC3, 8);
        cs_end();
        check("recover_addr", reg_addr, 4'd10);

        tick(10);
        check("wr_queue_empty", q_wr.size(), 0);
        check("rd_queue_empty", q_rd.size(), 0);
        check("miso_queue_empty", q_miso.size(), 0);
        check("miso_low_while_disabled", dis_miso_seen, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
